// File: rtl/meas_pkg.sv
// Shared encodings and constants for the frequency-meter measurement scheduler.
package meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LATCH = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  localparam logic [2:0] PAT_DUTY = 3'd1;
  localparam logic [2:0] PAT_PW   = 3'd2;
  localparam logic [2:0] UNIT_US  = 3'd6;
  localparam logic [2:0] UNIT_PCT = 3'd7;

  localparam logic [3:0] LED_DUTY = 4'b1111;
  localparam logic [3:0] LED_PW   = 4'b1110;
  localparam logic [3:0] LED_OFF  = 4'b0000;

  localparam int unsigned INVALID_CODE = 114514;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/meas_timer.sv
// Clear/enable up-counter with a terminal-count compare; saturates instead of wrapping.
module meas_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c = (cnt_q == term);

endmodule

// File: rtl/meas_scheduler.sv
// Sequences the duty-cycle and pulse-width measurement units from the keypad pattern
// and hands latched results to the OLED driver with a display-update strobe.
module meas_scheduler
  import meas_pkg::*;
#(
  parameter int unsigned DATAWIDTH    = 30,
  parameter int unsigned TIMEOUT_CYC  = 50_000_000,
  parameter int unsigned HOLD_CYC     = 10_000_000,
  parameter int unsigned INVALID_CODE = meas_pkg::INVALID_CODE
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [2:0]           pattern,
  input  logic [DATAWIDTH-1:0] cycle_duty,
  input  logic                 duty_valid,
  input  logic [DATAWIDTH-1:0] pulse_width_us,
  input  logic                 pw_valid,
  output logic                 start_duty,
  output logic                 start_pw,
  output logic [DATAWIDTH-1:0] data_fx,
  output logic [2:0]           unit,
  output logic [4:1]           led,
  output logic                 disp_update,
  output logic                 timeout,
  output logic                 busy
);

  localparam int unsigned TIMER_W = $clog2(max_u(TIMEOUT_CYC, HOLD_CYC));
  localparam logic [TIMER_W-1:0] TIMEOUT_TERM = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] HOLD_TERM    = TIMER_W'(HOLD_CYC - 1);

  state_e               state_q, state_d;
  logic [2:0]           pattern_q;
  logic                 duty_valid_q;
  logic                 pw_valid_q;
  logic                 inv_shown_q, inv_shown_d;
  logic [DATAWIDTH-1:0] data_fx_q, data_fx_d;
  logic [2:0]           unit_q, unit_d;
  logic [3:0]           led_q, led_d;
  logic                 timeout_q, timeout_d;
  logic                 start_duty_q, start_duty_d;
  logic                 start_pw_q, start_pw_d;
  logic                 disp_update_q, disp_update_d;
  logic                 busy_q, busy_d;

  logic                 pat_change_c;
  logic                 sel_duty_c;
  logic                 pat_valid_c;
  logic                 valid_edge_c;
  logic                 timer_clr_c;
  logic                 timer_en_c;
  logic [TIMER_W-1:0]   timer_term_c;
  logic                 timer_tc_c;

  // Decisions use the registered pattern; a mismatch with the live input is a change.
  assign pat_change_c = (pattern != pattern_q);
  assign sel_duty_c   = (pattern_q == PAT_DUTY);
  assign pat_valid_c  = (pattern_q == PAT_DUTY) || (pattern_q == PAT_PW);
  assign valid_edge_c = sel_duty_c ? (duty_valid & ~duty_valid_q)
                                   : (pw_valid & ~pw_valid_q);

  assign timer_term_c = (state_q == ST_HOLD) ? HOLD_TERM : TIMEOUT_TERM;
  assign timer_en_c   = (state_q == ST_WAIT) || (state_q == ST_HOLD);
  assign timer_clr_c  = pat_change_c || (state_d != state_q);

  meas_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .clr   (timer_clr_c),
    .en    (timer_en_c),
    .term  (timer_term_c),
    .tc_c  (timer_tc_c)
  );

  // Next-state and registered-output decode; a pattern change overrides everything.
  always_comb begin
    state_d       = state_q;
    inv_shown_d   = inv_shown_q;
    data_fx_d     = data_fx_q;
    unit_d        = unit_q;
    led_d         = led_q;
    timeout_d     = timeout_q;
    disp_update_d = 1'b0;

    if (pat_change_c) begin
      state_d     = ST_IDLE;
      inv_shown_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pat_valid_c) begin
            state_d = ST_ARM;
          end else if (!inv_shown_q) begin
            inv_shown_d   = 1'b1;
            data_fx_d     = DATAWIDTH'(INVALID_CODE);
            unit_d        = UNIT_PCT;
            led_d         = LED_OFF;
            timeout_d     = 1'b0;
            disp_update_d = 1'b1;
          end
        end
        ST_ARM: state_d = ST_WAIT;
        ST_WAIT: begin
          if (valid_edge_c) begin
            state_d = ST_LATCH;
          end else if (timer_tc_c) begin
            state_d       = ST_HOLD;
            data_fx_d     = '0;
            timeout_d     = 1'b1;
            disp_update_d = 1'b1;
          end
        end
        ST_LATCH: begin
          state_d       = ST_HOLD;
          data_fx_d     = sel_duty_c ? cycle_duty : pulse_width_us;
          unit_d        = sel_duty_c ? UNIT_PCT : UNIT_US;
          timeout_d     = 1'b0;
          disp_update_d = 1'b1;
        end
        ST_HOLD: begin
          if (timer_tc_c) begin
            state_d = ST_ARM;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Start pulse and LEDs are registered on entry so they appear during ARM.
    start_duty_d = (state_d == ST_ARM) && sel_duty_c;
    start_pw_d   = (state_d == ST_ARM) && !sel_duty_c;
    if (state_d == ST_ARM) begin
      led_d = sel_duty_c ? LED_DUTY : LED_PW;
    end
    busy_d = (state_d == ST_ARM) || (state_d == ST_WAIT);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      pattern_q     <= 3'd0;
      duty_valid_q  <= 1'b0;
      pw_valid_q    <= 1'b0;
      inv_shown_q   <= 1'b0;
      data_fx_q     <= '0;
      unit_q        <= UNIT_PCT;
      led_q         <= LED_OFF;
      timeout_q     <= 1'b0;
      start_duty_q  <= 1'b0;
      start_pw_q    <= 1'b0;
      disp_update_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pattern_q     <= pattern;
      duty_valid_q  <= duty_valid;
      pw_valid_q    <= pw_valid;
      inv_shown_q   <= inv_shown_d;
      data_fx_q     <= data_fx_d;
      unit_q        <= unit_d;
      led_q         <= led_d;
      timeout_q     <= timeout_d;
      start_duty_q  <= start_duty_d;
      start_pw_q    <= start_pw_d;
      disp_update_q <= disp_update_d;
      busy_q        <= busy_d;
    end
  end

  assign start_duty  = start_duty_q;
  assign start_pw    = start_pw_q;
  assign data_fx     = data_fx_q;
  assign unit        = unit_q;
  assign led         = led_q;
  assign disp_update = disp_update_q;
  assign timeout     = timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_meas_scheduler.sv
// Directed, table-driven bench for meas_scheduler with short timeout/hold periods.
module tb_meas_scheduler;

  localparam int unsigned DW = 30;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [2:0]    pattern = 3'd1;
  logic [DW-1:0] cycle_duty = '0;
  logic          duty_valid = 1'b0;
  logic [DW-1:0] pulse_width_us = '0;
  logic          pw_valid = 1'b0;
  logic          start_duty, start_pw, disp_update, timeout, busy;
  logic [DW-1:0] data_fx;
  logic [2:0]    unit;
  logic [4:1]    led;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  meas_scheduler #(
    .DATAWIDTH   (DW),
    .TIMEOUT_CYC (100),
    .HOLD_CYC    (20)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .pattern        (pattern),
    .cycle_duty     (cycle_duty),
    .duty_valid     (duty_valid),
    .pulse_width_us (pulse_width_us),
    .pw_valid       (pw_valid),
    .start_duty     (start_duty),
    .start_pw       (start_pw),
    .data_fx        (data_fx),
    .unit           (unit),
    .led            (led),
    .disp_update    (disp_update),
    .timeout        (timeout),
    .busy           (busy)
  );

  typedef struct packed {
    logic [4:0]    flags;  // {start_duty, start_pw, disp_update, busy, timeout}
    logic [DW-1:0] data;
    logic [2:0]    unit;
    logic [3:0]    led;
  } outs_t;

  typedef struct {
    logic [2:0]    pat;
    logic          dv;
    logic [DW-1:0] cd;
    logic          pv;
    logic [DW-1:0] pw;
    int            n;
    outs_t         exp;
  } vec_t;

  vec_t vecs[$];

  function automatic outs_t o(input logic [4:0] flags, input int unsigned data,
                              input int unsigned u, input logic [3:0] l);
    outs_t r;
    r.flags = flags;
    r.data  = DW'(data);
    r.unit  = 3'(u);
    r.led   = l;
    return r;
  endfunction

  task automatic add(input int unsigned pat, input logic dv, input int unsigned cd,
                     input logic pv, input int unsigned pw, input int n, input outs_t exp);
    vec_t v;
    v.pat = 3'(pat);
    v.dv  = dv;
    v.cd  = DW'(cd);
    v.pv  = pv;
    v.pw  = DW'(pw);
    v.n   = n;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string nm, input outs_t exp);
    outs_t got;
    got.flags = {start_duty, start_pw, disp_update, busy, timeout};
    got.data  = data_fx;
    got.unit  = unit;
    got.led   = led;
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {sd,sp,upd,busy,to}=%b data=%0d unit=%0d led=%b, expected %b data=%0d unit=%0d led=%b",
               nm, got.flags, got.data, got.unit, got.led, exp.flags, exp.data, exp.unit, exp.led);
    end
  endtask

  initial begin
    // Scenario 1: duty measurement, hold, re-arm
    add(1, 0, 0,    0, 0,    1,   o(5'b00000, 0, 7, 4'h0));
    add(1, 0, 0,    0, 0,    1,   o(5'b10010, 0, 7, 4'hF));
    add(1, 0, 0,    0, 0,    1,   o(5'b00010, 0, 7, 4'hF));
    add(1, 1, 500,  0, 0,    1,   o(5'b00000, 0, 7, 4'hF));
    add(1, 1, 500,  0, 0,    1,   o(5'b00100, 500, 7, 4'hF));
    add(1, 0, 500,  0, 0,    19,  o(5'b00000, 500, 7, 4'hF));
    add(1, 0, 500,  0, 0,    1,   o(5'b10010, 500, 7, 4'hF));
    add(1, 0, 500,  0, 0,    1,   o(5'b00010, 500, 7, 4'hF));
    // Scenario 2: switch to pulse width; stray duty_valid ignored
    add(2, 0, 500,  0, 0,    1,   o(5'b00000, 500, 7, 4'hF));
    add(2, 0, 500,  0, 0,    1,   o(5'b01010, 500, 7, 4'hE));
    add(2, 0, 500,  0, 0,    1,   o(5'b00010, 500, 7, 4'hE));
    add(2, 1, 9,    0, 0,    1,   o(5'b00010, 500, 7, 4'hE));
    add(2, 0, 9,    0, 0,    1,   o(5'b00010, 500, 7, 4'hE));
    add(2, 0, 9,    1, 1234, 1,   o(5'b00000, 500, 7, 4'hE));
    add(2, 0, 9,    1, 1234, 1,   o(5'b00100, 1234, 6, 4'hE));
    add(2, 0, 9,    0, 1234, 19,  o(5'b00000, 1234, 6, 4'hE));
    add(2, 0, 9,    0, 1234, 1,   o(5'b01010, 1234, 6, 4'hE));
    // Scenario 3: timeout, hold, re-arm, valid result clears timeout
    add(2, 0, 9,    0, 1234, 100, o(5'b00010, 1234, 6, 4'hE));
    add(2, 0, 9,    0, 1234, 1,   o(5'b00101, 0, 6, 4'hE));
    add(2, 0, 9,    0, 1234, 19,  o(5'b00001, 0, 6, 4'hE));
    add(2, 0, 9,    0, 1234, 1,   o(5'b01011, 0, 6, 4'hE));
    add(2, 0, 9,    0, 1234, 1,   o(5'b00011, 0, 6, 4'hE));
    add(2, 0, 9,    1, 77,   1,   o(5'b00001, 0, 6, 4'hE));
    add(2, 0, 9,    1, 77,   1,   o(5'b00100, 77, 6, 4'hE));
    // Scenario 4: invalid pattern, then back to duty
    add(5, 0, 9,    0, 77,   1,   o(5'b00000, 77, 6, 4'hE));
    add(5, 0, 9,    0, 77,   1,   o(5'b00100, 114514, 7, 4'h0));
    add(5, 0, 9,    0, 77,   5,   o(5'b00000, 114514, 7, 4'h0));
    add(1, 0, 9,    0, 77,   1,   o(5'b00000, 114514, 7, 4'h0));
    add(1, 0, 9,    0, 77,   1,   o(5'b10010, 114514, 7, 4'hF));
    add(1, 0, 9,    0, 77,   1,   o(5'b00010, 114514, 7, 4'hF));

    // Reset state, held over two clock edges
    step();
    chk("reset_a", o(5'b00000, 0, 7, 4'h0));
    step();
    chk("reset_b", o(5'b00000, 0, 7, 4'h0));
    sys_rst_n = 1'b1;

    foreach (vecs[i]) begin
      pattern        = vecs[i].pat;
      duty_valid     = vecs[i].dv;
      cycle_duty     = vecs[i].cd;
      pw_valid       = vecs[i].pv;
      pulse_width_us = vecs[i].pw;
      for (int c = 0; c < vecs[i].n; c++) begin
        step();
        chk($sformatf("vec%0d_cyc%0d", i, c), vecs[i].exp);
      end
    end

    // Scenario 5: pattern change coincides with a duty_valid edge in WAIT
    pattern = 3'd2; duty_valid = 1'b1; cycle_duty = DW'(999);
    step(); chk("chg_idle",  o(5'b00000, 114514, 7, 4'hF));
    step(); chk("chg_arm",   o(5'b01010, 114514, 7, 4'hE));
    step(); chk("chg_wait",  o(5'b00010, 114514, 7, 4'hE));
    pw_valid = 1'b1; pulse_width_us = DW'(4321);
    step(); chk("chg_latch", o(5'b00000, 114514, 7, 4'hE));
    step(); chk("chg_strobe", o(5'b00100, 4321, 6, 4'hE));
    pw_valid = 1'b0; duty_valid = 1'b0;

    // Scenario 6a: asynchronous reset during HOLD, then restart
    step(); step(); step();
    #2 sys_rst_n = 1'b0;
    #1 chk("rst_hold", o(5'b00000, 0, 7, 4'h0));
    #1 sys_rst_n = 1'b1;
    step(); chk("rst1_idle", o(5'b00000, 0, 7, 4'h0));
    step(); chk("rst1_arm",  o(5'b01010, 0, 7, 4'hE));
    step(); chk("rst1_wait", o(5'b00010, 0, 7, 4'hE));
    step(); chk("rst1_wait2", o(5'b00010, 0, 7, 4'hE));

    // Scenario 6b: asynchronous reset during WAIT, then a full measurement
    #2 sys_rst_n = 1'b0;
    #1 chk("rst_wait", o(5'b00000, 0, 7, 4'h0));
    #1 sys_rst_n = 1'b1;
    step(); chk("rst2_idle", o(5'b00000, 0, 7, 4'h0));
    step(); chk("rst2_arm",  o(5'b01010, 0, 7, 4'hE));
    step(); chk("rst2_wait", o(5'b00010, 0, 7, 4'hE));
    pw_valid = 1'b1; pulse_width_us = DW'(55);
    step(); chk("rst2_latch", o(5'b00000, 0, 7, 4'hE));
    step(); chk("rst2_strobe", o(5'b00100, 55, 6, 4'hE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
